vga_frame_checker: RTL

VGA_FRAME_CHECKER -- requirements
Module: vga_frame_checker

---
 rtl/vga_frame_checker_pkg.sv | 9 +
 rtl/crc32_step12.sv | 23 ++
 rtl/vga_frame_checker.sv | 98 +++++++++
 3 files changed

// File: rtl/vga_frame_checker_pkg.sv
// Shared constants for the VGA frame checker: CRC-32 parameters and FSM encoding.
package vga_frame_checker_pkg;
   localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

   localparam logic [0:0] WAIT_SYNC = 1'b0;
   localparam logic [0:0] CAPTURE   = 1'b1;
endpackage

// File: rtl/crc32_step12.sv
// Combinational CRC-32 advance by one 12-bit word, MSB first, non-reflected.
module crc32_step12
   import vga_frame_checker_pkg::*;
(
   input  logic [31:0] crc,
   input  logic [11:0] data,
   output logic [31:0] crc_next
);

   logic [31:0] c;

   always_comb begin
      c = crc;
      for (int i = 11; i >= 0; i--) begin
         if (c[31] ^ data[i])
            c = {c[30:0], 1'b0} ^ CRC_POLY;
         else
            c = {c[30:0], 1'b0};
      end
      crc_next = c;
   end

endmodule

// File: rtl/vga_frame_checker.sv
// Passive VGA stream monitor: per-frame CRC of active pixels plus line-length
// and line-count checks, aligned to the frame_ended pulse.
module vga_frame_checker
   import vga_frame_checker_pkg::*;
#(
   parameter int H_ACTIVE = 848,
   parameter int V_ACTIVE = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  vga_r,
   input  logic [3:0]  vga_g,
   input  logic [3:0]  vga_b,
   input  logic        vga_de,
   input  logic        frame_ended,
   output logic [31:0] frame_crc,
   output logic        frame_crc_valid,
   output logic [15:0] frame_count,
   output logic        line_len_error,
   output logic        line_count_error,
   output logic        synced
);

   logic [0:0]  state;
   logic [31:0] crc_run, crc_step, crc_cur;
   logic [11:0] pix_cnt, pix_inc, run_len;
   logic [10:0] line_cnt, line_inc, line_total;
   logic        de_q, line_end;

   crc32_step12 u_step (
      .crc      (crc_run),
      .data     ({vga_r, vga_g, vga_b}),
      .crc_next (crc_step)
   );

   assign crc_cur  = vga_de ? crc_step : crc_run;
   assign pix_inc  = (pix_cnt == 12'hFFF) ? pix_cnt : pix_cnt + 12'd1;
   assign line_inc = (line_cnt == 11'h7FF) ? line_cnt : line_cnt + 11'd1;

   // A run closes on de falling, or when frame_ended cuts it off while de is high
   assign line_end   = (de_q && !vga_de) || (frame_ended && vga_de);
   assign run_len    = vga_de ? pix_inc : pix_cnt;
   assign line_total = line_end ? line_inc : line_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= WAIT_SYNC;
         crc_run          <= CRC_INIT;
         pix_cnt          <= '0;
         line_cnt         <= '0;
         de_q             <= 1'b0;
         frame_crc        <= '0;
         frame_crc_valid  <= 1'b0;
         frame_count      <= '0;
         line_len_error   <= 1'b0;
         line_count_error <= 1'b0;
         synced           <= 1'b0;
      end else begin
         frame_crc_valid <= 1'b0;
         de_q            <= vga_de;
         if (state == WAIT_SYNC) begin
            if (frame_ended) begin
               state    <= CAPTURE;
               synced   <= 1'b1;
               crc_run  <= CRC_INIT;
               pix_cnt  <= '0;
               line_cnt <= '0;
               de_q     <= 1'b0;
            end
         end else begin
            if (vga_de) begin
               crc_run <= crc_step;
               pix_cnt <= pix_inc;
            end else begin
               pix_cnt <= '0;
            end
            if (line_end) begin
               line_cnt <= line_inc;
               if (run_len != 12'(H_ACTIVE))
                  line_len_error <= 1'b1;
            end
            // Frame close overrides the per-pixel updates above
            if (frame_ended) begin
               frame_crc       <= crc_cur ^ CRC_XOROUT;
               frame_crc_valid <= 1'b1;
               frame_count     <= frame_count + 16'd1;
               if (line_total != 11'(V_ACTIVE))
                  line_count_error <= 1'b1;
               crc_run  <= CRC_INIT;
               pix_cnt  <= '0;
               line_cnt <= '0;
               de_q     <= 1'b0;
            end
         end
      end
   end

endmodule
